// File: rtl/rv32i_types.sv
// Shared RV32I load-path types and helpers.
//   load_funct3_t : RV32I load funct3 encodings (lb, lh, lw, lbu, lhu)
//   load_state_t  : load_aligner FSM states (IDLE, READ, DONE)
//   lane_enable() : cache byte enables for a funct3 / address-offset pair
//   is_misaligned(): true for lh/lhu on an odd address or word-class on a non-word address
package rv32i_types;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // Undefined funct3 values fall into the default arm and read as a full word.
    function automatic logic [3:0] lane_enable(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (funct3)
            LB, LBU: be = 4'b0001 << offset;
            LH, LHU: be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        case (funct3)
            LB, LBU: mis = 1'b0;
            LH, LHU: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load result extraction.
//   funct3    : load funct3 of the request
//   offset    : address bits [1:0] of the request
//   mem_rdata : aligned word from the data cache
//   result    : selected byte/halfword/word, sign- or zero-extended to 32 bits
module load_extract
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_field;
    logic [15:0] half_field;

    always_comb begin
        byte_field = 8'h00;
        half_field = 16'h0000;
        case (offset)
            2'd0:    byte_field = mem_rdata[7:0];
            2'd1:    byte_field = mem_rdata[15:8];
            2'd2:    byte_field = mem_rdata[23:16];
            default: byte_field = mem_rdata[31:24];
        endcase
        // Halfword selection only looks at offset[1]; offset[0] is ignored.
        half_field = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        result = mem_rdata;
        case (funct3)
            LB:      result = {{24{byte_field[7]}}, byte_field};
            LH:      result = {{16{half_field[15]}}, half_field};
            LBU:     result = {24'h000000, byte_field};
            LHU:     result = {16'h0000, half_field};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// Load aligner: accepts one load, issues one word-aligned cache read, waits for
// the response and registers the extracted, extended result for writeback.
// Optional feature macro: LOAD_MISALIGN_TRAP_EN (misaligned lh/lhu/lw complete
// immediately with ld_misaligned=1 and rd_data=0, without a cache read).
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   ld_valid/ld_funct3/ld_address  : load request, taken while ld_ready=1
//   ld_ready                       : idle, request can be accepted
//   ld_done, rd_data, ld_misaligned: one-cycle completion pulse and result
//   mem_read/mem_address/mem_byte_enable : cache read request (from latched request)
//   mem_resp/mem_rdata             : cache response, only honoured in READ
//   state                          : FSM state, for observation
// Handshake: a request transfers on a rising edge where ld_valid=1 and
// ld_ready=1; mem_read stays high until the edge where mem_resp=1.
module load_aligner
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [2:0]       ld_funct3,
    input  logic [width-1:0] ld_address,
    output logic             ld_ready,
    output logic             ld_done,
    output logic [31:0]      rd_data,
    output logic             ld_misaligned,
    output logic             mem_read,
    output logic [width-1:0] mem_address,
    output logic [3:0]       mem_byte_enable,
    input  logic             mem_resp,
    input  logic [31:0]      mem_rdata,
    output load_state_t      state
);

    load_state_t      next_state;
    logic [2:0]       req_funct3;
    logic [width-1:0] req_addr;
    logic [3:0]       req_be;
    logic [31:0]      extracted;
    logic             accept;
    logic             capture;
    logic             trap;

`ifdef LOAD_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign trap          = is_misaligned(ld_funct3, ld_address[1:0]);
    assign ld_misaligned = misaligned_q && (state == DONE);
`else
    assign trap          = 1'b0;
    assign ld_misaligned = 1'b0;
`endif

    load_extract u_extract (
        .funct3    (req_funct3),
        .offset    (req_addr[1:0]),
        .mem_rdata (mem_rdata),
        .result    (extracted)
    );

    assign mem_address     = {req_addr[width-1:2], 2'b00};
    assign mem_byte_enable = req_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        mem_read   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    accept     = 1'b1;
                    next_state = trap ? DONE : READ;
                end
            end
            READ: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                ld_done    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch and result register. The byte enables are registered
    // rather than decoded so that they read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_funct3 <= 3'b000;
            req_addr   <= '0;
            req_be     <= 4'b0000;
            rd_data    <= 32'h0;
        end else if (accept) begin
            req_funct3 <= ld_funct3;
            req_addr   <= ld_address;
            req_be     <= lane_enable(ld_funct3, ld_address[1:0]);
            if (trap) rd_data <= 32'h0;
        end else if (capture) begin
            rd_data <= extracted;
        end
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         misaligned_q <= 1'b0;
        else if (accept) misaligned_q <= trap;
    end
`endif

endmodule

// File: tb/tb_load_aligner.sv
// Self-checking bench for load_aligner: directed cases followed by random loads
// checked against an arithmetic reference model and an expected-result queue.
module tb_load_aligner;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_address;
    logic        ld_ready;
    logic        ld_done;
    logic [31:0] rd_data;
    logic        ld_misaligned;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    load_state_t state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    load_aligner #(.width(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_valid        (ld_valid),
        .ld_funct3       (ld_funct3),
        .ld_address      (ld_address),
        .ld_ready        (ld_ready),
        .ld_done         (ld_done),
        .rd_data         (rd_data),
        .ld_misaligned   (ld_misaligned),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .state           (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr,
                                             input logic [31:0] data);
        int lane;
        longint b;
        longint h;
        lane = int'(addr % 4);
        b = (longint'(data) >> (8 * lane)) % 256;
        h = (longint'(data) >> (16 * (lane / 2))) % 65536;
        case (f3)
            0:       return (b >= 128) ? 32'(b - 256) : 32'(b);
            1:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            4:       return 32'(b);
            5:       return 32'(h);
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input int f3, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        if (f3 == 0 || f3 == 4) return 4'(1 << lane);
        if (f3 == 1 || f3 == 5) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic bit ref_trap(input int f3, input logic [31:0] addr);
`ifdef LOAD_MISALIGN_TRAP_EN
        int lane;
        lane = int'(addr % 4);
        if (f3 == 0 || f3 == 4) return 1'b0;
        if (f3 == 1 || f3 == 5) return (lane % 2) == 1;
        return lane != 0;
`else
        return 1'b0;
`endif
    endfunction

    // driver: one complete load; waits = READ cycles before the response
    task automatic do_load(input int f3, input logic [31:0] addr, input logic [31:0] data,
                           input int waits, input bit noise);
        logic [31:0] exp;
        bit trapped;
        trapped = ref_trap(f3, addr);
        exp_q.push_back(trapped ? 32'h0 : ref_load(f3, addr, data));
        check("ready_before", 32'(ld_ready), 32'd1);
        ld_valid   = 1'b1;
        ld_funct3  = 3'(f3);
        ld_address = addr;
        @(posedge clk); #1;
        if (noise) begin
            ld_valid   = 1'b1;
            ld_funct3  = 3'($urandom);
            ld_address = $urandom;
        end else begin
            ld_valid = 1'b0;
        end
        if (!trapped) begin
            for (int i = 0; i <= waits; i++) begin
                check("mem_read", 32'(mem_read), 32'd1);
                check("mem_address", mem_address, {addr[31:2], 2'b00});
                check("byte_enable", 32'(mem_byte_enable), 32'(ref_be(f3, addr)));
                check("done_early", 32'(ld_done), 32'd0);
                check("ready_busy", 32'(ld_ready), 32'd0);
                mem_resp  = (i == waits);
                mem_rdata = (i == waits) ? data : $urandom;
                @(posedge clk); #1;
            end
            mem_resp = 1'b0;
        end
        // DONE cycle
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("ld_done", 32'(ld_done), 32'd1);
        check("rd_data", rd_data, exp);
        check("ld_misaligned", 32'(ld_misaligned), 32'(trapped));
        check("mem_read_done", 32'(mem_read), 32'd0);
        ld_valid = 1'b0;
        @(posedge clk); #1;
        check("ready_after", 32'(ld_ready), 32'd1);
        check("done_pulse", 32'(ld_done), 32'd0);
        if (noise) begin
            // a stray response while idle must not disturb the result
            mem_resp  = 1'b1;
            mem_rdata = $urandom;
            @(posedge clk); #1;
            mem_resp = 1'b0;
            check("rd_hold", rd_data, exp);
            check("idle_stale", 32'(ld_done), 32'd0);
        end
    endtask

    initial begin
        int f3_tab[8];
        f3_tab = '{0, 1, 2, 4, 5, 3, 6, 7};
        rst = 1'b1; ld_valid = 1'b0; ld_funct3 = 3'b0; ld_address = 32'h0;
        mem_resp = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_ready", 32'(ld_ready), 32'd1);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_misaligned", 32'(ld_misaligned), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_byte_enable", 32'(mem_byte_enable), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a read
        ld_valid = 1'b1; ld_funct3 = 3'b010; ld_address = 32'h5000;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        check("mid_mem_read", 32'(mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mem_read", 32'(mem_read), 32'd0);
        check("mid_rst_state", 32'(state), 32'(IDLE));
        check("mid_rst_ready", 32'(ld_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        check("mid_rst_rd_data", rd_data, 32'h0);
        check("mid_rst_no_done", 32'(ld_done), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_no_done2", 32'(ld_done), 32'd0);

        // directed loads
        do_load(0, 32'h1003, 32'h80FF_0000, 3, 1'b0);
        do_load(4, 32'h1003, 32'h80FF_0000, 1, 1'b0);
        do_load(1, 32'h2002, 32'h8001_1234, 0, 1'b0);
        do_load(5, 32'h2000, 32'h8001_1234, 2, 1'b0);
        do_load(2, 32'h3000, 32'hDEAD_BEEF, 0, 1'b1);
        do_load(2, 32'h4001, 32'hCAFE_F00D, 0, 1'b0);
        do_load(3, 32'h4003, 32'h0BAD_F00D, 1, 1'b0);

        // random loads
        for (int k = 0; k < 60; k++) begin
            do_load(f3_tab[$urandom_range(0, 7)], $urandom, $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
